sr_latch_writer: RTL and testbench
==================================

Name: sr_latch_writer

Overview:
Clocked write sequencer that sits directly upstream of the gated SR latch and closes the loop on its outputs. It accepts a one-bit write request and drives S, R and En with a setup, pulse and release sequence. After a settle interval it samples Q and notQ, then reports completion with an error flag. It guarantees that S=R=1 is never presented to the latch and that S/R only change while En is low.

Parameters:
HOLD_CYCLES, 2, Clk cycles En is held high per write (legal range 1..15).
SETTLE_CYCLES, 2, Clk cycles after En falls before Q/notQ are sampled (legal range 1..15). SETTLE_CYCLES x Tclk must be at least 3 NAND delays (12 ns).
CNT_W, 4, width of the internal cycle counter; must hold max(HOLD_CYCLES, SETTLE_CYCLES).

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-high reset.
Req  input  1  write request; sampled only when Ready=1.
Data  input  1  bit to store; captured with Req.
Ready  output  1  high only in IDLE.
S  output  1  latch set input.
R  output  1  latch reset input.
En  output  1  latch enable.
Q_in  input  1  latch Q, fed back.
notQ_in  input  1  latch notQ, fed back.
Done  output  1  one-cycle completion pulse.
Err  output  1  result flag, valid while Done=1 and held until the next Done.
Stored  output  1  Q_in value sampled at check, held until the next Done.

Behaviour:
- Only one clock and one reset: Clk, plus Rst, which is asynchronous and active-high.
- All outputs are registered or decoded from state registers; none depends combinationally on Req, Data, Q_in or notQ_in.
- Reset values: state=IDLE, Ready=1, S=0, R=0, En=0, Done=0, Err=0, Stored=0, counter=0, captured data=0.
- States and transitions:
  - IDLE: Ready=1, S=R=En=0. Req=1 at an edge captures Data, goes to SETUP.
  - SETUP: one cycle. S=Data, R=~Data, En=0. Goes to PULSE.
  - PULSE: HOLD_CYCLES cycles. S/R unchanged, En=1. Goes to SETTLE when the counter reaches HOLD_CYCLES-1.
  - SETTLE: SETTLE_CYCLES cycles. En=0, S=R=0. At the final SETTLE edge, Q_in is registered into Stored and Err is computed. Goes to CHECK.
  - CHECK: one cycle. Done=1. Goes to IDLE.
- Err=1 if Stored != captured Data, or if Q_in == notQ_in at the sample edge (invalid or metastable latch state).
- Latency: Req accepted at edge 0. Done is high during cycle HOLD_CYCLES+SETTLE_CYCLES+2; with defaults, Done is high in cycle 6. Ready returns the cycle after Done.
- The counter clears on every state entry and has no wrap-around; the terminal count is compared exactly.
- Req while busy (Ready=0) is ignored and not queued. Data changes after capture have no effect.
- Back-to-back: Req=1 held continuously starts a new write on the first IDLE edge, giving one write every HOLD_CYCLES+SETTLE_CYCLES+3 cycles.
- Invariants, checked by the bench each cycle: never S=1 with R=1; S and R never change in a cycle where En=1; En=1 only in PULSE.
- Reset mid-operation forces all outputs to their reset values immediately, without waiting for Clk. En drops, so the latch keeps whatever it holds; no Done is issued for the aborted write.
- Rst held high with Clk running keeps the block in IDLE, with Ready at its reset value.

Test Plan:
- Write 1: Rst pulse, then Req=1, Data=1 at edge 0, latch model ideal -> S=1, R=0 in cycles 1-3; En=1 in cycles 2-3; Done=1 in cycle 6 with Stored=1, Err=0; Ready=1 in cycle 7.
- Write 0 after write 1: Data=0 -> R=1, S=0 in cycles 1-3; Done in cycle 6; Stored=0, Err=0; the latch Q toggles 1->0 during PULSE.
- Busy request: second Req=1, Data=0 at cycle 3 during PULSE -> ignored; exactly one Done pulse, Stored=1.
- Fault injection: bench forces Q_in=0, notQ_in=1 while writing 1 -> Done in cycle 6 with Err=1, Stored=0. Force Q_in=notQ_in=1 -> Err=1.
- Reset mid-PULSE: Rst=1 asserted between edges in cycle 2 -> En, S, R and Ready settle to 0/0/0/1 before the next Clk edge; no Done follows. The latch retains its prior value.
- Back-to-back, HOLD_CYCLES=1 and SETTLE_CYCLES=3, Req held high with Data alternating 1,0,1 -> Done every 7 cycles, Err=0 each time, and the S/R exclusivity invariant is never violated.

Source files
------------

// File: rtl/sr_latch_writer.sv
// sr_latch_writer: clocked write sequencer for a gated SR latch.
// Drives S/R/En through a setup, pulse and release sequence.
// After a settle interval it samples the latch outputs and reports Done with an error flag.
// Every output is a register, so none of them can glitch or follow Req/Data/Q_in combinationally.
module sr_latch_writer #(
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Req,
  input  logic Data,
  output logic Ready,
  output logic S,
  output logic R,
  output logic En,
  input  logic Q_in,
  input  logic notQ_in,
  output logic Done,
  output logic Err,
  output logic Stored
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4
  } stateT;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  stateT            state;
  stateT            stateNext;
  logic             dataReg;
  logic             dataNext;
  logic [CNT_W-1:0] cnt;
  logic             driveSR;
  logic             sampleNow;

  // Next-state decode; Data is captured only on the IDLE edge that accepts a request.
  always_comb begin
    stateNext = state;
    dataNext  = dataReg;
    case (state)
      IDLE: begin
        if (Req) begin
          stateNext = SETUP;
          dataNext  = Data;
        end
      end
      SETUP:  stateNext = PULSE;
      PULSE:  if (cnt == HOLD_LAST) stateNext = SETTLE;
      SETTLE: if (cnt == SETTLE_LAST) stateNext = CHECK;
      CHECK:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    driveSR   = (stateNext == SETUP) || (stateNext == PULSE);
    sampleNow = (state == SETTLE) && (stateNext == CHECK);
  end

  // State, counter and registered outputs.
  // Outputs are computed from the next state, so S/R/En all switch on the same edge as the state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      dataReg <= 1'b0;
      cnt     <= '0;
      Ready   <= 1'b1;
      S       <= 1'b0;
      R       <= 1'b0;
      En      <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      Stored  <= 1'b0;
    end else begin
      state   <= stateNext;
      dataReg <= dataNext;
      if (stateNext != state) begin
        cnt <= '0;
      end else if ((state == PULSE) || (state == SETTLE)) begin
        cnt <= cnt + CNT_W'(1);
      end
      Ready <= (stateNext == IDLE);
      S     <= driveSR && dataNext;
      R     <= driveSR && !dataNext;
      En    <= (stateNext == PULSE);
      Done  <= (stateNext == CHECK);
      if (sampleNow) begin
        Stored <= Q_in;
        Err    <= (Q_in != dataReg) || (Q_in == notQ_in);
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Testbench for sr_latch_writer.
// A table of single writes runs on a default instance driving an ideal latch model.
// Hand-written sequences then cover an abort by reset and back-to-back writes on a second instance.
module tb_sr_latch_writer;

  logic Clk, Rst;
  logic Req, Data, Ready, S, R, En, Done, Err, Stored, QIn, notQIn;
  logic Req2, Data2, Ready2, S2, R2, En2, Done2, Err2, Stored2, QIn2, notQIn2;
  logic latchQ, latchQ2;
  int   faultMode;
  int   checks;
  int   errors;
  logic prevS, prevR, prevEn, prevS2, prevR2, prevEn2;

  typedef struct {
    logic data;
    int   fault;
    int   busyCycle;
    logic expStored;
    logic expErr;
    logic expLatch;
  } vecT;

  vecT vecs[6];

  sr_latch_writer dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Data(Data), .Ready(Ready),
    .S(S), .R(R), .En(En), .Q_in(QIn), .notQ_in(notQIn),
    .Done(Done), .Err(Err), .Stored(Stored)
  );

  sr_latch_writer #(.HOLD_CYCLES(1), .SETTLE_CYCLES(3), .CNT_W(4)) dut2 (
    .Clk(Clk), .Rst(Rst), .Req(Req2), .Data(Data2), .Ready(Ready2),
    .S(S2), .R(R2), .En(En2), .Q_in(QIn2), .notQ_in(notQIn2),
    .Done(Done2), .Err(Err2), .Stored(Stored2)
  );

  // Fault 1 pins the latch at Q=0/notQ=1; fault 2 makes both outputs high.
  assign QIn     = (faultMode == 1) ? 1'b0 : (faultMode == 2) ? 1'b1 : latchQ;
  assign notQIn  = (faultMode == 0) ? ~latchQ : 1'b1;
  assign QIn2    = latchQ2;
  assign notQIn2 = ~latchQ2;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Ideal gated latches: while enabled they follow S/R, otherwise they hold.
  always @(negedge Clk) begin
    if (En) begin
      if (S && !R) latchQ = 1'b1;
      else if (R && !S) latchQ = 1'b0;
    end
    if (En2) begin
      if (S2 && !R2) latchQ2 = 1'b1;
      else if (R2 && !S2) latchQ2 = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  // Per-cycle invariants on both instances: S/R exclusive, S/R stable while En stays high,
  // and En never coinciding with the IDLE or CHECK phases.
  task automatic checkInvariants();
    logic bad;
    logic bad2;
    if (!Rst) begin
      bad  = (S && R) || (prevEn && En && ((S !== prevS) || (R !== prevR))) || (En && (Ready || Done));
      bad2 = (S2 && R2) || (prevEn2 && En2 && ((S2 !== prevS2) || (R2 !== prevR2))) || (En2 && (Ready2 || Done2));
      checkOutput("invariant_dut", bad, 1'b0);
      checkOutput("invariant_dut2", bad2, 1'b0);
    end
    prevS   = S;
    prevR   = R;
    prevEn  = Rst ? 1'b0 : En;
    prevS2  = S2;
    prevR2  = R2;
    prevEn2 = Rst ? 1'b0 : En2;
  endtask

  task automatic waitSample();
    @(negedge Clk);
    #1;
    checkInvariants();
  endtask

  // One write on the default instance, checked against the hand-written cycle timeline:
  // SETUP=1, PULSE=2..3, SETTLE=4..5, CHECK=6, IDLE=7.
  task automatic applyStimulus(input int idx, input vecT v);
    faultMode = v.fault;
    Req  = 1'b1;
    Data = v.data;
    @(posedge Clk);
    for (int c = 1; c <= 7; c++) begin
      waitSample();
      checkOutput($sformatf("v%0d_c%0d_Ready", idx, c), Ready, (c == 7));
      checkOutput($sformatf("v%0d_c%0d_S", idx, c), S, (c <= 3) && v.data);
      checkOutput($sformatf("v%0d_c%0d_R", idx, c), R, (c <= 3) && !v.data);
      checkOutput($sformatf("v%0d_c%0d_En", idx, c), En, (c == 2) || (c == 3));
      checkOutput($sformatf("v%0d_c%0d_Done", idx, c), Done, (c == 6));
      if (c >= 6) begin
        checkOutput($sformatf("v%0d_c%0d_Stored", idx, c), Stored, v.expStored);
        checkOutput($sformatf("v%0d_c%0d_Err", idx, c), Err, v.expErr);
      end
      if (c == v.busyCycle) begin
        Req  = 1'b1;
        Data = ~v.data;
      end else begin
        Req = 1'b0;
      end
    end
    checkOutput($sformatf("v%0d_latch", idx), latchQ, v.expLatch);
    faultMode = 0;
  endtask

  initial begin
    logic expB2B [3];
    int   b2bIdx;
    logic isDone;

    checks    = 0;
    errors    = 0;
    faultMode = 0;
    latchQ    = 1'b0;
    latchQ2   = 1'b0;
    prevS = 0; prevR = 0; prevEn = 0; prevS2 = 0; prevR2 = 0; prevEn2 = 0;

    //          data  fault busy stored err  latch
    vecs[0] = '{1'b1, 0,    0,   1'b1,  1'b0, 1'b1};
    vecs[1] = '{1'b0, 0,    0,   1'b0,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 0,    3,   1'b1,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 1,    0,   1'b0,  1'b1, 1'b1};
    vecs[4] = '{1'b1, 2,    0,   1'b1,  1'b1, 1'b1};
    vecs[5] = '{1'b0, 0,    0,   1'b0,  1'b0, 1'b0};

    // Reset held with the clock running and Req high keeps both instances idle.
    Rst = 1'b1; Req = 1'b1; Data = 1'b1; Req2 = 1'b0; Data2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      waitSample();
      checkOutput($sformatf("rst%0d_Ready", i), Ready, 1'b1);
      checkOutput($sformatf("rst%0d_En", i), En, 1'b0);
      checkOutput($sformatf("rst%0d_S", i), S, 1'b0);
      checkOutput($sformatf("rst%0d_Done", i), Done, 1'b0);
      checkOutput($sformatf("rst%0d_Stored", i), Stored, 1'b0);
      checkOutput($sformatf("rst%0d_Ready2", i), Ready2, 1'b1);
    end
    Req = 1'b0;
    Rst = 1'b0;
    waitSample();
    checkOutput("postrst_Ready", Ready, 1'b1);
    checkOutput("postrst_Err", Err, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Abort a write of 1 in its second cycle (PULSE); outputs must drop before the next edge.
    Req = 1'b1; Data = 1'b1;
    @(posedge Clk);
    waitSample();
    Req = 1'b0;
    waitSample();
    checkOutput("abort_En_before", En, 1'b1);
    #2 Rst = 1'b1;
    #1;
    checkOutput("abort_En", En, 1'b0);
    checkOutput("abort_S", S, 1'b0);
    checkOutput("abort_R", R, 1'b0);
    checkOutput("abort_Ready", Ready, 1'b1);
    checkOutput("abort_Done", Done, 1'b0);
    waitSample();
    waitSample();
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitSample();
      checkOutput($sformatf("abort_nodone%0d", i), Done, 1'b0);
    end
    checkOutput("abort_latch", latchQ, 1'b1);

    // Back-to-back writes on the HOLD=1/SETTLE=3 instance with Req held high: Done every 7 cycles.
    expB2B[0] = 1'b1; expB2B[1] = 1'b0; expB2B[2] = 1'b1;
    b2bIdx = 0;
    Req2 = 1'b1; Data2 = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 21; c++) begin
      waitSample();
      isDone = ((c % 7) == 6);
      checkOutput($sformatf("b2b_c%0d_Done", c), Done2, isDone);
      if (isDone) begin
        checkOutput($sformatf("b2b_c%0d_Stored", c), Stored2, expB2B[b2bIdx]);
        checkOutput($sformatf("b2b_c%0d_Err", c), Err2, 1'b0);
        b2bIdx++;
      end
      if (c == 1) Data2 = 1'b0;
      if (c == 8) Data2 = 1'b1;
      if (c == 20) Req2 = 1'b0;
    end
    waitSample();
    checkOutput("b2b_final_Ready", Ready2, 1'b1);
    waitSample();
    checkOutput("b2b_final_idle_Ready", Ready2, 1'b1);
    checkOutput("b2b_final_idle_En", En2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
